// File: rtl/gpr_fwd_scoreboard.sv
// rtl/gpr_fwd_scoreboard.sv - ID-stage GPR forwarding, hazard detection and long-unit scoreboard
module gpr_fwd_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2,
    parameter int STAGES   = 3,
    parameter int LU_LAT   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         id_valid,
    input  logic [RD_PORTS-1:0]          rd_used,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    input  logic [RD_PORTS*DATA_W-1:0]   rf_rdata,
    input  logic                         id_we,
    input  logic [ADDR_W-1:0]            id_waddr,
    input  logic                         id_lu_start,
    input  logic [STAGES-1:0]            st_we,
    input  logic [STAGES*ADDR_W-1:0]     st_waddr,
    input  logic [STAGES*DATA_W-1:0]     st_wdata,
    input  logic [STAGES-1:0]            st_ready,
    input  logic [DATA_W-1:0]            lu_result,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic                         stall,
    output logic                         lu_issue,
    output logic                         lu_busy,
    output logic                         lu_done,
    output logic [ADDR_W-1:0]            lu_waddr,
    output logic [15:0]                  stall_cnt
);

    localparam int CNT_W = $clog2(LU_LAT + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;

    logic [RD_PORTS-1:0] port_haz;
    logic [ADDR_W-1:0]   addr;
    logic                hit;
    logic                not_rdy;
    logic                lu_block;
    logic                waw_haz;
    logic                struct_haz;

    assign lu_busy   = (state_q == S_BUSY);
    assign lu_done   = lu_busy && (cnt_q == CNT_W'(1));
    assign lu_block  = lu_busy & ~lu_done;
    assign lu_waddr  = waddr_q;
    assign stall_cnt = stall_cnt_q;

    // Only the first matching source counts; a not-ready youngest match must not fall through to an older ready one.
    always_comb begin
        rd_data  = '0;
        port_haz = '0;
        addr     = '0;
        hit      = 1'b0;
        not_rdy  = 1'b0;
        for (int p = 0; p < RD_PORTS; p++) begin
            addr    = rd_addr[p*ADDR_W +: ADDR_W];
            hit     = 1'b0;
            not_rdy = 1'b0;
            rd_data[p*DATA_W +: DATA_W] = rf_rdata[p*DATA_W +: DATA_W];
            if (addr != '0) begin
                if (lu_done && (waddr_q == addr)) begin
                    rd_data[p*DATA_W +: DATA_W] = lu_result;
                    hit = 1'b1;
                end
                for (int s = 0; s < STAGES; s++) begin
                    if (!hit && st_we[s] && (st_waddr[s*ADDR_W +: ADDR_W] == addr)) begin
                        rd_data[p*DATA_W +: DATA_W] = st_wdata[s*DATA_W +: DATA_W];
                        hit     = 1'b1;
                        not_rdy = ~st_ready[s];
                    end
                end
                port_haz[p] = rd_used[p] & (not_rdy | (lu_block & (waddr_q == addr)));
            end
        end
    end

    assign waw_haz    = id_we & lu_block & (waddr_q == id_waddr) & (id_waddr != '0);
    assign struct_haz = id_lu_start & lu_block;
    assign stall      = id_valid & ((|port_haz) | waw_haz | struct_haz);
    assign lu_issue   = id_valid & id_lu_start & ~stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        if (state_q == S_IDLE) begin
            if (lu_issue) begin
                state_d = S_BUSY;
                cnt_d   = CNT_W'(LU_LAT);
                waddr_d = id_waddr;
            end
        end else if (lu_done) begin
            // Issuing in the done cycle chains straight into the next op.
            if (lu_issue) begin
                cnt_d   = CNT_W'(LU_LAT);
                waddr_d = id_waddr;
            end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            waddr_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            waddr_q     <= waddr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_gpr_fwd_scoreboard.sv
// tb/tb_gpr_fwd_scoreboard.sv - randomized scoreboard bench for gpr_fwd_scoreboard
module tb_gpr_fwd_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RP = 2;
    localparam int ST = 3;
    localparam int LL = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [RP-1:0]     rd_used;
    logic [RP*AW-1:0]  rd_addr;
    logic [RP*DW-1:0]  rf_rdata;
    logic              id_we;
    logic [AW-1:0]     id_waddr;
    logic              id_lu_start;
    logic [ST-1:0]     st_we;
    logic [ST*AW-1:0]  st_waddr;
    logic [ST*DW-1:0]  st_wdata;
    logic [ST-1:0]     st_ready;
    logic [DW-1:0]     lu_result;
    logic [RP*DW-1:0]  rd_data;
    logic              stall;
    logic              lu_issue;
    logic              lu_busy;
    logic              lu_done;
    logic [AW-1:0]     lu_waddr;
    logic [15:0]       stall_cnt;

    always #5 clk = ~clk;

    gpr_fwd_scoreboard #(
        .DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP), .STAGES(ST), .LU_LAT(LL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rd_used(rd_used),
        .rd_addr(rd_addr), .rf_rdata(rf_rdata), .id_we(id_we), .id_waddr(id_waddr),
        .id_lu_start(id_lu_start), .st_we(st_we), .st_waddr(st_waddr),
        .st_wdata(st_wdata), .st_ready(st_ready), .lu_result(lu_result),
        .rd_data(rd_data), .stall(stall), .lu_issue(lu_issue), .lu_busy(lu_busy),
        .lu_done(lu_done), .lu_waddr(lu_waddr), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [RP*DW-1:0] rd_data;
        logic             stall;
        logic             lu_issue;
        logic             lu_busy;
        logic             lu_done;
        logic [AW-1:0]    lu_waddr;
        logic [15:0]      stall_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: the long op is described by the cycle it issued in.
    int            m_cyc   = 0;
    int            m_issue = -1;
    logic [AW-1:0] m_dst   = '0;
    int            m_scnt  = 0;

    task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        exp_t          e;
        logic          busy, done, blk, haz, found, nr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (!rst_n) begin
            m_issue = -1;
            m_dst   = '0;
            m_scnt  = 0;
        end
        busy = (m_issue >= 0) && (m_cyc > m_issue) && (m_cyc <= m_issue + LL);
        done = busy && (m_cyc == m_issue + LL);
        blk  = busy && !done;
        haz  = 1'b0;
        e    = '0;
        for (int p = 0; p < RP; p++) begin
            a     = rd_addr[p*AW +: AW];
            d     = rf_rdata[p*DW +: DW];
            found = 1'b0;
            nr    = 1'b0;
            if (a != 0) begin
                if (done && m_dst == a) begin
                    d     = lu_result;
                    found = 1'b1;
                end
                for (int s = 0; s < ST; s++) begin
                    if (!found && st_we[s] && st_waddr[s*AW +: AW] == a) begin
                        d     = st_wdata[s*DW +: DW];
                        nr    = !st_ready[s];
                        found = 1'b1;
                    end
                end
                if (id_valid && rd_used[p] && (nr || (blk && m_dst == a))) haz = 1'b1;
            end
            e.rd_data[p*DW +: DW] = d;
        end
        if (id_valid && id_we && blk && m_dst == id_waddr && id_waddr != 0) haz = 1'b1;
        if (id_valid && id_lu_start && blk) haz = 1'b1;
        e.stall     = haz;
        e.lu_issue  = id_valid && id_lu_start && !haz;
        e.lu_busy   = busy;
        e.lu_done   = done;
        e.lu_waddr  = m_dst;
        e.stall_cnt = m_scnt[15:0];
        exp_q.push_back(e);
        if (rst_n) begin
            if (e.lu_issue) begin
                m_issue = m_cyc;
                m_dst   = id_waddr;
            end
            if (haz && m_scnt < 65535) m_scnt++;
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        id_valid = 1'b0; rd_used = '0; rd_addr = '0; rf_rdata = '0;
        id_we = 1'b0; id_waddr = '0; id_lu_start = 1'b0;
        st_we = '0; st_waddr = '0; st_wdata = '0; st_ready = '1; lu_result = '0;
    endtask

    initial begin : monitor
        exp_t e;
        int   mcyc;
        mcyc = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data",   mcyc, 64'(rd_data),   64'(e.rd_data));
                chk("stall",     mcyc, 64'(stall),     64'(e.stall));
                chk("lu_issue",  mcyc, 64'(lu_issue),  64'(e.lu_issue));
                chk("lu_busy",   mcyc, 64'(lu_busy),   64'(e.lu_busy));
                chk("lu_done",   mcyc, 64'(lu_done),   64'(e.lu_done));
                chk("lu_waddr",  mcyc, 64'(lu_waddr),  64'(e.lu_waddr));
                chk("stall_cnt", mcyc, 64'(stall_cnt), 64'(e.stall_cnt));
                mcyc++;
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0;
        quiet();
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Forwarding priority and the zero register
        id_valid = 1'b1; rd_used = 2'b01; rd_addr = {5'd0, 5'd5};
        rf_rdata = {32'h1111_0000, 32'h2222_0000};
        st_we = 3'b111; st_waddr = {5'd5, 5'd5, 5'd5}; st_ready = 3'b111;
        st_wdata = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        cycle();
        st_we = 3'b110;
        cycle();
        rd_addr = '0;
        cycle();

        // Load-use: a not-ready youngest match hides an older ready one
        st_we = 3'b011; st_waddr = {5'd0, 5'd7, 5'd7}; st_ready = 3'b110;
        rd_addr = {5'd7, 5'd0}; rd_used = 2'b10;
        cycle();
        rd_used = 2'b00;
        cycle();

        // Long op to r9, then a reader of r9 held until released
        quiet();
        id_valid = 1'b1; id_lu_start = 1'b1; id_we = 1'b1; id_waddr = 5'd9;
        cycle();
        id_lu_start = 1'b0; id_we = 1'b0;
        rd_used = 2'b01; rd_addr = {5'd0, 5'd9}; lu_result = 32'hDEAD_BEEF;
        repeat (5) cycle();

        // WAW, then a structural conflict resolved in the done cycle
        quiet();
        id_valid = 1'b1; id_lu_start = 1'b1; id_we = 1'b1; id_waddr = 5'd9;
        cycle();
        id_lu_start = 1'b0;
        cycle();
        id_lu_start = 1'b1; id_waddr = 5'd10;
        repeat (4) cycle();
        quiet();
        repeat (5) cycle();

        // Asynchronous reset with the counter at 2
        id_valid = 1'b1; id_lu_start = 1'b1; id_we = 1'b1; id_waddr = 5'd12;
        cycle();
        quiet();
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (6) cycle();

        // Random traffic over a small register window to force collisions
        repeat (3000) begin
            rst_n       = ($urandom_range(0, 599) != 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            rd_used     = RP'($urandom());
            for (int p = 0; p < RP; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            rf_rdata    = {$urandom(), $urandom()};
            id_we       = 1'($urandom());
            id_waddr    = AW'($urandom_range(0, 7));
            id_lu_start = ($urandom_range(0, 3) == 0);
            st_we       = ST'($urandom());
            for (int s = 0; s < ST; s++) begin
                st_waddr[s*AW +: AW] = AW'($urandom_range(0, 7));
                st_wdata[s*DW +: DW] = $urandom();
                st_ready[s]          = ($urandom_range(0, 4) != 0);
            end
            lu_result   = $urandom();
            cycle();
        end
        rst_n = 1'b1;

        // Saturation of the stall counter
        quiet();
        id_valid = 1'b1; rd_used = 2'b01; rd_addr = {5'd0, 5'd3};
        st_we = 3'b001; st_waddr = {5'd0, 5'd0, 5'd3}; st_ready = 3'b110;
        repeat (70000) cycle();
        quiet();
        cycle();
        cycle();

        repeat (5) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
